// File: rtl/keccak_theta_step.sv
`default_nettype none

// +------------------------------------------------------------------------+
// | keccak_pkg                                                             |
// | Keccak-f[1600] state geometry shared by the permutation stages.        |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
package keccak_pkg;
   localparam int ROW_SIZE  = 5;    // x coordinates
   localparam int COL_SIZE  = 5;    // y coordinates
   localparam int LANE_SIZE = 64;   // z coordinates (lane width w)
endpackage

// +------------------------------------------------------------------------+
// | keccak_theta_step                                                      |
// | Registered Keccak-f[1600] theta step with a valid/ready handshake.     |
// | Every bit is XORed with the parities of two neighbouring columns and   |
// | the result is held in a one-deep output register.                      |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module keccak_theta_step
   import keccak_pkg::*;
(
   input  logic                                                 clk,
   input  logic                                                 rst_n,
   input  logic                                                 in_valid,
   output logic                                                 in_ready,
   input  logic [ROW_SIZE-1:0][COL_SIZE-1:0][LANE_SIZE-1:0]     state_array_in,
   output logic                                                 out_valid,
   input  logic                                                 out_ready,
   output logic [ROW_SIZE-1:0][COL_SIZE-1:0][LANE_SIZE-1:0]     state_array_out
);

   // XOR of the five lanes that make up one sheet (fixed x), giving the
   // parity of every column of that sheet in a single lane-wide word.
   function automatic logic [LANE_SIZE-1:0] lane_parity(
      input logic [COL_SIZE-1:0][LANE_SIZE-1:0] sheet
   );
      logic [LANE_SIZE-1:0] acc;
      acc = '0;
      for (int y = 0; y < COL_SIZE; y++) begin
         acc = acc ^ sheet[y];
      end
      return acc;
   endfunction

   logic [ROW_SIZE-1:0][LANE_SIZE-1:0]                    col_parity;
   logic [ROW_SIZE-1:0][LANE_SIZE-1:0]                    d_mix;
   logic [ROW_SIZE-1:0][COL_SIZE-1:0][LANE_SIZE-1:0]      theta_result;

   logic                                                  out_valid_d;
   logic                                                  out_valid_q;
   logic [ROW_SIZE-1:0][COL_SIZE-1:0][LANE_SIZE-1:0]      state_out_d;
   logic [ROW_SIZE-1:0][COL_SIZE-1:0][LANE_SIZE-1:0]      state_out_q;

   logic                                                  accept;

   // Theta datapath: column parities, per-sheet mixing term, then the XOR
   // back into every lane. Neighbour indices are resolved at elaboration so
   // the x wrap (mod 5) costs nothing; the z-1 term is a rotate-left by one,
   // which makes bit 0 pick up bit 63.
   for (genvar gx = 0; gx < ROW_SIZE; gx++) begin : g_sheet
      localparam int X_PREV = (gx + ROW_SIZE - 1) % ROW_SIZE;
      localparam int X_NEXT = (gx + 1) % ROW_SIZE;

      assign col_parity[gx] = lane_parity(state_array_in[gx]);

      assign d_mix[gx] = col_parity[X_PREV]
                       ^ {col_parity[X_NEXT][LANE_SIZE-2:0],
                          col_parity[X_NEXT][LANE_SIZE-1]};

      for (genvar gy = 0; gy < COL_SIZE; gy++) begin : g_lane
         assign theta_result[gx][gy] = state_array_in[gx][gy] ^ d_mix[gx];
      end
   end

   // The stage can take a new state whenever its register is empty or the
   // current result is leaving this cycle.
   assign in_ready = !out_valid_q || out_ready;
   assign accept   = in_valid && in_ready;

   // Next-state for the output register: load on accept, drop valid when the
   // result is consumed with nothing new behind it, otherwise hold. The data
   // word is left untouched on drain so it only ever changes on accept.
   always_comb begin
      out_valid_d = out_valid_q;
      state_out_d = state_out_q;
      if (accept) begin
         out_valid_d = 1'b1;
         state_out_d = theta_result;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   // Output register; reset clears both valid and data immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         state_out_q <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         state_out_q <= state_out_d;
      end
   end

   assign out_valid       = out_valid_q;
   assign state_array_out = state_out_q;

endmodule

`default_nettype wire

// File: tb/tb_keccak_theta_step.sv
`default_nettype none

// +------------------------------------------------------------------------+
// | tb_keccak_theta_step                                                   |
// | Self-checking bench for keccak_theta_step: directed vector table,      |
// | backpressure and reset sequences, randomized streaming vs. a model.    |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_keccak_theta_step;
   import keccak_pkg::*;

   typedef logic [ROW_SIZE-1:0][COL_SIZE-1:0][LANE_SIZE-1:0] state_t;

   typedef struct {
      string  name;
      state_t din;
      state_t exp;
   } vec_t;

   logic   clk;
   logic   rst_n;
   logic   in_valid;
   logic   in_ready;
   state_t state_array_in;
   logic   out_valid;
   logic   out_ready;
   state_t state_array_out;

   int n_pass;
   int n_total;

   keccak_theta_step dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .state_array_in  (state_array_in),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .state_array_out (state_array_out)
   );

   // 10 ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Watchdog so the run always ends
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, actual=running required=finished");
      $fatal(1, "timeout");
   end

   // Reference theta written straight from the bit-level definition:
   // column parity by counting ones, then neighbour lookups with mod wrap.
   function automatic state_t theta_ref(input state_t a);
      bit     par [ROW_SIZE][LANE_SIZE];
      state_t r;
      for (int x = 0; x < ROW_SIZE; x++) begin
         for (int z = 0; z < LANE_SIZE; z++) begin
            int cnt;
            cnt = 0;
            for (int y = 0; y < COL_SIZE; y++) cnt += int'(a[x][y][z]);
            par[x][z] = bit'(cnt % 2);
         end
      end
      for (int x = 0; x < ROW_SIZE; x++)
         for (int y = 0; y < COL_SIZE; y++)
            for (int z = 0; z < LANE_SIZE; z++)
               r[x][y][z] = a[x][y][z]
                          ^ par[(x + 4) % 5][z]
                          ^ par[(x + 1) % 5][(z + 63) % 64];
      return r;
   endfunction

   function automatic state_t rand_state();
      state_t s;
      for (int x = 0; x < ROW_SIZE; x++)
         for (int y = 0; y < COL_SIZE; y++)
            s[x][y] = {$urandom(), $urandom()};
      return s;
   endfunction

   task automatic check_bit(input string name, input logic act, input logic exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: actual=%b required=%b", name, act, exp);
   endtask

   task automatic check_state(input string name, input state_t act, input state_t exp);
      n_total++;
      if (act === exp) begin
         n_pass++;
      end else begin
         int fx, fy;
         fx = -1; fy = -1;
         for (int x = ROW_SIZE - 1; x >= 0; x--)
            for (int y = COL_SIZE - 1; y >= 0; y--)
               if (act[x][y] !== exp[x][y]) begin fx = x; fy = y; end
         $display("FAIL %s: lane[%0d][%0d] actual=%h required=%h",
                  name, fx, fy, act[fx][fy], exp[fx][fy]);
      end
   endtask

   vec_t   vecs [4];
   state_t s1, s2, junk, last_exp, exp_next;
   logic   prev_acc;

   initial begin
      n_pass         = 0;
      n_total        = 0;
      rst_n          = 1'b0;
      in_valid       = 1'b0;
      out_ready      = 1'b1;
      state_array_in = '0;

      // ---------------- directed vector table ----------------
      vecs[0].name = "single_bit_000";
      vecs[0].din  = '0;
      vecs[0].din[0][0] = 64'h1;
      vecs[0].exp  = '0;
      vecs[0].exp[0][0] = 64'h1;
      for (int y = 0; y < COL_SIZE; y++) begin
         vecs[0].exp[1][y] = 64'h0000000000000001;
         vecs[0].exp[4][y] = 64'h0000000000000002;
      end

      vecs[1].name = "wrap_bit_2_3_63";
      vecs[1].din  = '0;
      vecs[1].din[2][3] = 64'h8000000000000000;
      vecs[1].exp  = '0;
      vecs[1].exp[2][3] = 64'h8000000000000000;
      for (int y = 0; y < COL_SIZE; y++) begin
         vecs[1].exp[3][y] = 64'h8000000000000000;
         vecs[1].exp[1][y] = 64'h0000000000000001;
      end

      vecs[2].name = "all_ones";
      vecs[2].din  = '1;
      vecs[2].exp  = '1;

      vecs[3].name = "all_zero";
      vecs[3].din  = '0;
      vecs[3].exp  = '0;

      // ---------------- reset state ----------------
      repeat (2) @(negedge clk);
      check_bit  ("reset_out_valid", out_valid, 1'b0);
      check_state("reset_state_out", state_array_out, '0);
      check_bit  ("reset_in_ready", in_ready, 1'b1);
      rst_n = 1'b1;

      // ---------------- table: accept then drain ----------------
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         state_array_in = vecs[i].din;
         in_valid       = 1'b1;
         @(negedge clk);
         check_bit  ({vecs[i].name, "_valid"}, out_valid, 1'b1);
         check_state({vecs[i].name, "_data"}, state_array_out, vecs[i].exp);
         in_valid = 1'b0;
         @(negedge clk);
         check_bit  ({vecs[i].name, "_drain_valid"}, out_valid, 1'b0);
         check_state({vecs[i].name, "_drain_hold"}, state_array_out, vecs[i].exp);
      end

      // ---------------- backpressure ----------------
      s1   = rand_state();
      s2   = rand_state();
      junk = rand_state();
      out_ready      = 1'b0;
      state_array_in = s1;
      in_valid       = 1'b1;
      @(negedge clk);
      check_bit  ("bp_accept_valid", out_valid, 1'b1);
      check_state("bp_accept_data", state_array_out, theta_ref(s1));
      state_array_in = junk;
      for (int k = 0; k < 3; k++) begin
         #1;
         check_bit("bp_in_ready_low", in_ready, 1'b0);
         @(negedge clk);
         check_bit  ("bp_hold_valid", out_valid, 1'b1);
         check_state("bp_hold_data", state_array_out, theta_ref(s1));
      end
      out_ready      = 1'b1;
      state_array_in = s2;
      #1;
      check_bit("bp_release_in_ready", in_ready, 1'b1);
      @(negedge clk);
      check_bit  ("bp_replace_valid", out_valid, 1'b1);
      check_state("bp_replace_data", state_array_out, theta_ref(s2));
      in_valid = 1'b0;
      @(negedge clk);
      check_bit("bp_drain_valid", out_valid, 1'b0);

      // ---------------- randomized streaming ----------------
      prev_acc = 1'b0;
      last_exp = theta_ref(s2);
      for (int k = 0; k < 40; k++) begin
         state_array_in = rand_state();
         in_valid       = ($urandom_range(0, 4) != 0);
         exp_next       = theta_ref(state_array_in);
         #1;
         check_bit("stream_in_ready", in_ready, 1'b1);
         @(negedge clk);
         check_bit  ("stream_valid", out_valid, in_valid);
         if (in_valid) last_exp = exp_next;
         check_state("stream_data", state_array_out, last_exp);
      end
      in_valid = 1'b0;
      @(negedge clk);
      check_bit  ("stream_drain_valid", out_valid, 1'b0);
      check_state("stream_drain_hold", state_array_out, last_exp);

      // ---------------- asynchronous reset mid-operation ----------------
      out_ready      = 1'b0;
      state_array_in = rand_state();
      in_valid       = 1'b1;
      @(negedge clk);
      check_bit("midrst_pending_valid", out_valid, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      check_bit  ("midrst_out_valid", out_valid, 1'b0);
      check_state("midrst_state_out", state_array_out, '0);
      check_bit  ("midrst_in_ready", in_ready, 1'b1);
      in_valid = 1'b0;
      @(negedge clk);
      rst_n          = 1'b1;
      out_ready      = 1'b1;
      s1             = rand_state();
      state_array_in = s1;
      in_valid       = 1'b1;
      @(negedge clk);
      check_bit  ("post_rst_valid", out_valid, 1'b1);
      check_state("post_rst_data", state_array_out, theta_ref(s1));
      in_valid = 1'b0;
      @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire
